// File: rtl/max_pool_pkg.sv
// Shared types, default geometry and helpers for the streaming max-pool stage.
package max_pool_pkg;

  localparam int unsigned DEF_BITWIDTH = 8;
  localparam int unsigned DEF_IMG_W    = 8;
  localparam int unsigned DEF_IMG_H    = 8;
  localparam int unsigned DEF_K        = 2;

  localparam int unsigned POOL_W = DEF_IMG_W / DEF_K;
  localparam int unsigned COL_W  = $clog2(DEF_IMG_W);
  localparam int unsigned ROW_W  = $clog2(DEF_IMG_H);

  typedef logic [DEF_BITWIDTH-1:0] pix_t;

  function automatic pix_t pmax(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_row_buffer.sv
// Row buffer of per-window partial maxima: one synchronous write port, one asynchronous read port.
module pool_row_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/max_pool_stream_2d.sv
// Streaming KxK stride-K max-pool: horizontal running max, row buffer of partials, one output register.
module max_pool_stream_2d
  import max_pool_pkg::*;
#(
  parameter int unsigned BITWIDTH = DEF_BITWIDTH,
  parameter int unsigned IMG_W    = DEF_IMG_W,
  parameter int unsigned IMG_H    = DEF_IMG_H,
  parameter int unsigned K        = DEF_K
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] out_data,
  output logic                out_last
);

  localparam int unsigned POOL_N   = IMG_W / K;
  localparam int unsigned COL_BITS = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_BITS = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned AW       = (POOL_N > 1) ? $clog2(POOL_N) : 1;

  function automatic logic [BITWIDTH-1:0] vmax(input logic [BITWIDTH-1:0] a,
                                               input logic [BITWIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [COL_BITS-1:0] col;
  logic [ROW_BITS-1:0] row;
  logic [BITWIDTH-1:0] hmax;

  logic                accept, close, last_col, last_row;
  logic                wr_en;
  int unsigned         kx, ky;
  logic [AW-1:0]       wx;
  logic [BITWIDTH-1:0] h, rb_rd, wr_data, pooled;

  assign in_ready = !clear && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    kx       = 32'(col) % K;
    ky       = 32'(row) % K;
    wx       = AW'(32'(col) / K);
    last_col = (col == COL_BITS'(IMG_W - 1));
    last_row = (row == ROW_BITS'(IMG_H - 1));
    h        = (kx == 0) ? in_data : vmax(hmax, in_data);
    close    = accept && (kx == K - 1);
    pooled   = vmax(rb_rd, h);
    wr_en    = close && (ky != K - 1);
    wr_data  = (ky == 0) ? h : pooled;
  end

  pool_row_buffer #(
    .DEPTH (POOL_N),
    .WIDTH (BITWIDTH),
    .AW    (AW)
  ) u_row_buffer (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wx),
    .wdata (wr_data),
    .raddr (wx),
    .rdata (rb_rd)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col       <= '0;
      row       <= '0;
      hmax      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (clear) begin
      col       <= '0;
      row       <= '0;
      hmax      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (accept) begin
        hmax <= h;
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      // A bottom-row close reloads the register even while it drains, keeping out_valid high.
      if (close && (ky == K - 1)) begin
        out_valid <= 1'b1;
        out_data  <= pooled;
        out_last  <= last_row && last_col;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_max_pool_stream_2d.sv
// Scoreboard bench for max_pool_stream_2d on a 4x4 frame with 2x2 pooling.
module tb_max_pool_stream_2d;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_last;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  bit          rdy_rand = 1'b0;
  logic [8:0]  sb [$];

  always #5 clk = ~clk;

  max_pool_stream_2d #(
    .BITWIDTH (8),
    .IMG_W    (4),
    .IMG_H    (4),
    .K        (2)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Random downstream readiness
  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
  end

  // Output monitor: handshake completes at the following posedge
  initial forever begin
    @(negedge clk);
    if (rstn && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", {31'd0, out_valid}, 32'd0);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        check("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
        check("out_last", {31'd0, out_last}, {31'd0, e[8]});
      end
    end
  end

  // Entry and exit at posedge+1
  task automatic send_pixel(input logic [7:0] v, input bit gaps);
    int unsigned n;
    bit ok;
    n = 0;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = v;
    forever begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      n++;
      if (n > 1000) begin
        check("accept_timeout", 32'd1, 32'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f [16], input bit gaps);
    for (int wy = 0; wy < 2; wy++) begin
      for (int wx = 0; wx < 2; wx++) begin
        logic [7:0] m;
        m = '0;
        for (int dy = 0; dy < 2; dy++)
          for (int dx = 0; dx < 2; dx++)
            if (f[(2*wy + dy)*4 + 2*wx + dx] > m) m = f[(2*wy + dy)*4 + 2*wx + dx];
        sb.push_back({(wy == 1 && wx == 1), m});
      end
    end
    for (int i = 0; i < 16; i++) send_pixel(f[i], gaps);
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", sb.size(), 32'd0);
  endtask

  logic [7:0] fr [16];

  initial begin
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Ascending frame, always ready
    for (int i = 0; i < 16; i++) fr[i] = 8'(i + 1);
    send_frame(fr, 1'b0);
    drain();

    // Downstream stall while the first result is presented
    out_ready = 1'b0;
    fork
      send_frame(fr, 1'b0);
      begin
        int unsigned n;
        n = 0;
        forever begin
          @(negedge clk);
          if (out_valid || n > 200) break;
          n++;
        end
        check("stall_seen_valid", {31'd0, out_valid}, 32'd1);
        for (int c = 0; c < 3; c++) begin
          check("stall_hold_valid", {31'd0, out_valid}, 32'd1);
          check("stall_hold_data", {24'd0, out_data}, 32'd6);
          check("stall_in_ready", {31'd0, in_ready}, 32'd0);
          if (c < 2) @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Saturated frame then zero frame
    for (int i = 0; i < 16; i++) fr[i] = 8'd255;
    send_frame(fr, 1'b0);
    for (int i = 0; i < 16; i++) fr[i] = 8'd0;
    send_frame(fr, 1'b0);
    drain();

    // Abort a partial frame with clear, then descending frame
    for (int i = 0; i < 5; i++) send_pixel(8'(i + 1), 1'b0);
    clear = 1'b1;
    #1;
    check("clear_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clear_out_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 16; i++) fr[i] = 8'(16 - i);
    send_frame(fr, 1'b0);
    drain();

    // Asynchronous reset while a result is held
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_pixel(8'(i + 1), 1'b0);
    @(negedge clk);
    check("prerst_valid", {31'd0, out_valid}, 32'd1);
    check("prerst_data", {24'd0, out_data}, 32'd6);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_last", {31'd0, out_last}, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) fr[i] = 8'(i + 1);
    send_frame(fr, 1'b0);
    drain();

    // Random gaps and backpressure over 20 frames
    rdy_rand = 1'b1;
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < 16; i++) fr[i] = 8'($urandom_range(0, 255));
      send_frame(fr, 1'b1);
    end
    drain();
    rdy_rand = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("final_idle_valid", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
